// File: rtl/conv_stream_feeder_if.sv
// conv_stream_feeder_if: memory read port plus AXI-Stream master bundle
interface conv_stream_feeder_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 23
);
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;
  modport master (
    output mem_en, mem_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  mem_rdata, m_axis_tready
  );
  modport slave (
    input  mem_en, mem_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output mem_rdata, m_axis_tready
  );
endinterface

// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder: streams one kernel block plus the image from a sync-read memory onto AXI-Stream
module conv_stream_feeder #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [1:0]            CHANNEL_SIZE_choose,
  input  logic [2:0]            IMAGE_SIZE_choose,
  conv_stream_feeder_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] base_q, n_q, rd_cnt, tx_cnt, c_words, n_next;
  logic [DATA_WIDTH-1:0] out_data, skid_data;
  logic out_valid, skid_valid, rd_pend, pop, issue, last, refill;
  logic [1:0] used;
  // N = C + I*I*C, with I*I*C folded into a single shift of C
  always_comb begin
    c_words = ADDR_WIDTH'(256) >> CHANNEL_SIZE_choose;
    n_next  = c_words + (c_words << ({IMAGE_SIZE_choose, 1'b0} + 4'd4));
    pop     = out_valid & bus.m_axis_tready;
    last    = tx_cnt == n_q - ADDR_WIDTH'(1);
    used    = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(pop);
    issue   = state == RUN && rd_cnt < n_q && used < 2'd2;
    refill  = pop | ~out_valid;
  end
  assign bus.mem_en        = issue;
  assign bus.mem_addr      = base_q + rd_cnt;
  assign bus.m_axis_tdata  = out_data;
  assign bus.m_axis_tvalid = out_valid;
  assign bus.m_axis_tlast  = out_valid & last;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      base_q     <= '0;
      n_q        <= '0;
      rd_cnt     <= '0;
      tx_cnt     <= '0;
      out_data   <= '0;
      skid_data  <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      rd_pend    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      rd_pend    <= issue;
      rd_cnt     <= rd_cnt + ADDR_WIDTH'(issue);
      tx_cnt     <= tx_cnt + ADDR_WIDTH'(pop);
      out_valid  <= refill ? skid_valid | rd_pend : out_valid;
      skid_valid <= refill ? skid_valid & rd_pend : skid_valid | rd_pend;
      if (refill && (skid_valid || rd_pend)) out_data <= skid_valid ? skid_data : bus.mem_rdata;
      if (rd_pend) skid_data <= bus.mem_rdata;
      case (state)
        IDLE: if (start) begin
          cfg_err <= IMAGE_SIZE_choose > 3'd5;
          if (IMAGE_SIZE_choose <= 3'd5) begin
            state  <= RUN;
            busy   <= 1'b1;
            base_q <= base_addr;
            n_q    <= n_next;
            rd_cnt <= '0;
            tx_cnt <= '0;
          end
        end
        RUN: if (pop && last) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_conv_stream_feeder.sv
// tb_conv_stream_feeder: random-ready stream checks against an address-indexed memory reference
module tb_conv_stream_feeder;
  logic clk = 1'b0;
  logic reset, start, busy, done, cfg_err;
  logic [22:0] base_addr;
  logic [1:0] ch;
  logic [2:0] img;
  int checks = 0, failures = 0;
  int idx = 0, rd_seen = 0, exp_n = 0;
  logic [22:0] exp_base = '0;
  logic stall_q = 1'b0;
  logic [255:0] stall_d = '0;

  conv_stream_feeder_if #(.DATA_WIDTH(256), .ADDR_WIDTH(23)) bus ();

  conv_stream_feeder #(.DATA_WIDTH(256), .ADDR_WIDTH(23)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .CHANNEL_SIZE_choose(ch), .IMAGE_SIZE_choose(img), .bus(bus),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] word(input logic [22:0] a);
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = {9'd0, a} * 32'h9E3779B1 + 32'(k);
    return w;
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) if (bus.mem_en) bus.mem_rdata <= word(bus.mem_addr);

  always @(negedge clk)
    if (reset) stall_q = 1'b0;
    else begin
      if (stall_q) begin
        check("hold_valid", bus.m_axis_tvalid, 1);
        check("hold_data", bus.m_axis_tdata, stall_d);
      end
      if (bus.mem_en) begin
        check("rd_addr", bus.mem_addr, 23'(exp_base + 23'(rd_seen)));
        check("rd_range", rd_seen < exp_n, 1);
        rd_seen++;
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        check("extra_word", idx < exp_n, 1);
        check("data", bus.m_axis_tdata, word(23'(exp_base + 23'(idx))));
        check("tlast", bus.m_axis_tlast, idx == exp_n - 1);
        idx++;
      end
      stall_q = bus.m_axis_tvalid && !bus.m_axis_tready;
      stall_d = bus.m_axis_tdata;
    end

  // mode 0: ready held 1, 1: random ready plus a stray start, 2: stall 20 then release, 3: abort at word 100
  task automatic run(input logic [1:0] ch_i, input logic [2:0] img_i, input logic [22:0] base_i,
                     input int mode, input int limit);
    int c, i, cyc, hold, rel;
    c = 256 >> ch_i;
    i = 4 << img_i;
    ch = ch_i; img = img_i; base_addr = base_i;
    exp_base = base_i; exp_n = c + i * i * c; idx = 0; rd_seen = 0;
    bus.m_axis_tready = mode == 0 || mode == 3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_on", busy, 1);
    check("first_rd", {bus.mem_en, bus.mem_addr}, {1'b1, base_i});
    cyc = 0; hold = 0; rel = 0;
    while (!done && cyc < limit) begin
      if (mode == 1) begin
        bus.m_axis_tready = 1'($urandom_range(0, 1));
        start = cyc == 50;
        if (cyc == 50) begin base_addr = 23'h7000; ch = 2'd0; end
      end
      @(posedge clk); #1;
      cyc++;
      if ((mode == 0 || mode == 3) && cyc <= 2) check("tvalid_lat", bus.m_axis_tvalid, cyc == 2);
      if (mode == 3 && idx == 100) return;
      if (mode == 2 && bus.m_axis_tvalid && !bus.m_axis_tready) begin
        hold++;
        if (hold == 20) begin
          check("stall_reads", rd_seen, 2);
          bus.m_axis_tready = 1'b1;
          rel = cyc;
        end
      end
    end
    start = 1'b0;
    check("timeout", cyc < limit, 1);
    check("words", idx, exp_n);
    check("reads", rd_seen, exp_n);
    check("busy_off", busy, 0);
    if (mode == 0) check("latency", cyc, exp_n + 2);
    if (mode == 2) check("no_bubble", cyc - rel, exp_n);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
    check({tag, "_tlast"}, bus.m_axis_tlast, 0);
    check({tag, "_tdata"}, bus.m_axis_tdata, 0);
    check({tag, "_mem_en"}, bus.mem_en, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; ch = '0; img = '0;
    bus.m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk); #1;
    run(2'd0, 3'd0, 23'h0, 0, 4400);
    run(2'd3, 3'd0, 23'h100, 1, 8000);
    exp_n = 0; rd_seen = 0;
    for (int k = 6; k < 8; k++) begin
      img = 3'(k); ch = 2'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("cfg_err_on", cfg_err, 1);
      check("cfg_busy", busy, 0);
      check("cfg_mem_en", bus.mem_en, 0);
      @(posedge clk); #1;
      check("cfg_err_off", cfg_err, 0);
    end
    run(2'd3, 3'd0, 23'h200, 2, 700);
    for (int k = 0; k < 2; k++)
      run(2'($urandom_range(2, 3)), 3'($urandom_range(0, 1)), 23'($urandom_range(0, 23'h3FFFFF)), 1, 40000);
    run(2'd0, 3'd0, 23'h40, 3, 400);
    #2 reset = 1'b1;
    #1 check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    run(2'd0, 3'd0, 23'h40, 0, 4400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_stream_feeder.md
# conv_stream_feeder

Synthesizable AXI-Stream source that feeds `top_level_conv`'s 256-bit `s_axis` slave port. On a start pulse it reads one kernel block (CHANNEL_SIZE words) followed by the full input image (IMAGE_SIZE²·CHANNEL_SIZE words) from a synchronous-read memory port, then streams them in address order with `tlast` on the final word. It replaces the behavioural DDR model used in conv simulation and sits between the DDR/BRAM read side and the conv core, configured by the same AXI-GPIO size selects.

## Interface
- `DATA_WIDTH`, 256, stream/memory word width
- `ADDR_WIDTH`, 23, memory word-address width (max transfer 4,194,560 words)
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  single-cycle request; sampled only in IDLE
- `base_addr`  in  ADDR_WIDTH  first word address, latched on accepted start
- `CHANNEL_SIZE_choose`  in  2  0→256, 1→128, 2→64, 3→32 channels
- `IMAGE_SIZE_choose`  in  3  0→4, 1→8, 2→16, 3→32, 4→64, 5→128; 6,7 invalid
- `mem_en`  out  1  read strobe
- `mem_addr`  out  ADDR_WIDTH  read address
- `mem_rdata`  in  DATA_WIDTH  read data, valid exactly 1 cycle after `mem_en`
- `m_axis_tdata`  out  DATA_WIDTH  stream data
- `m_axis_tvalid`  out  1  stream valid
- `m_axis_tlast`  out  1  high with the final word only
- `m_axis_tready`  in  1  sink ready
- `busy`  out  1  high from accepted start until final handshake
- `done`  out  1  one-cycle pulse after final handshake
- `cfg_err`  out  1  one-cycle pulse when start rejected for invalid size

## Operation
- Total words N = C + I·I·C (C, I from choose inputs), computed and latched at accepted start along with base_addr. Choose inputs ignored while busy.
- FSM: IDLE → RUN on start with valid IMAGE_SIZE_choose; start with choose 6/7 stays in IDLE, pulses `cfg_err`. RUN → DONE on handshake of word N; DONE → IDLE unconditionally after one cycle (`done`=1 in DONE).
- Read issue counter `rd_cnt` (0..N) and send counter `tx_cnt` (0..N). Reads issued at `base_addr + rd_cnt`, strictly increasing, no wrap beyond base+N−1.
- Output buffering: output register plus one skid register (2 entries). Issue a read in a cycle only if rd_cnt < N and (occupied entries + reads in flight − pop this cycle) < 2. Guarantees no data loss under arbitrary `tready`.
- Handshake = `tvalid & tready`; on handshake the skid entry (if any) moves to output. `tdata`/`tlast` stable while `tvalid & !tready`; `tvalid` never drops without a handshake.
- `tlast` = 1 exactly when the output entry is word N−1 (tx_cnt == N−1).
- `start` in RUN or DONE ignored; no queuing.

## Timing
- Reset values: `mem_en`=0, `mem_addr`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0, `done`=0, `cfg_err`=0, state IDLE, counters 0. Reset mid-stream aborts immediately; no residual words after release.
- Start sampled at edge E0: `busy`=1 and first `mem_en` (addr=base) in cycle after E0; `m_axis_tvalid` high 2 cycles after E0.
- With `tready` held 1: one word per cycle, N handshakes in N consecutive cycles; `done` pulses the cycle after last handshake; `busy` falls with `done`.
- `tready` low: at most 2 words buffered; reads stall; resumption gives back-to-back words with no bubble.
- Simultaneous pop and refill in same cycle allowed; skid never overflows.
- New start accepted earliest the cycle after `done`.

## Test plan
- C=256, I=4 (choose 0/0), base 0, tready=1: 4352 words equal mem[0..4351] in order, tlast only on word 4352, done 1 cycle later, total 4354 cycles start→done.
- C=32, I=4 (3/0), base 0x100, random tready (50%): 544 words, addresses 0x100..0x31F exactly once, no drop/duplicate, tdata stable while stalled.
- tready held 0 for 20 cycles after first valid: exactly 2 `mem_en` issued, then stall; release → contiguous words, correct sequence.
- start pulsed in RUN and with IMAGE_SIZE_choose=6 in IDLE: first ignored (stream unchanged), second gives `cfg_err` pulse, busy stays 0, no mem_en.
- reset asserted at word 100 of a 4352 transfer: tvalid/busy drop asynchronously, all outputs at reset values; new start after release restarts from base, word 0 first.
